// File: rtl/ysyx_22040088_cache_mem_slave_if.sv
// Refill / write-back bus between an L1 cache (master) and the memory slave.
interface ysyx_22040088_cache_mem_slave_if;
   logic        rd_req;
   logic [3:0]  rd_wstrb;
   logic [63:0] rd_addr;
   logic        rd_rdy;
   logic        ret_valid;
   logic        ret_last;
   logic [63:0] ret_data;
   logic        wr_req;
   logic [3:0]  wr_wstrb;
   logic [63:0] wr_addr;
   logic [63:0] wr_data;
   logic        wr_rdy;

   modport master (
      output rd_req, rd_wstrb, rd_addr, wr_req, wr_wstrb, wr_addr, wr_data,
      input  rd_rdy, ret_valid, ret_last, ret_data, wr_rdy
   );

   modport slave (
      input  rd_req, rd_wstrb, rd_addr, wr_req, wr_wstrb, wr_addr, wr_data,
      output rd_rdy, ret_valid, ret_last, ret_data, wr_rdy
   );
endinterface

// File: rtl/ysyx_22040088_cache_mem_slave.sv
// Memory-side responder for L1 refills/stores: word-addressed 64-bit store with fixed read latency.
// Optional CACHE_MEM_SLAVE_ERR_EN adds a sticky out-of-range `err` output and a poison read pattern.
module ysyx_22040088_cache_mem_slave #(
   parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000,
   parameter int unsigned MEM_WORDS = 32'd1024,
   parameter int unsigned BEATS     = 32'd1,
   parameter int unsigned LAT       = 32'd2
) (
   input  logic clk,
   input  logic rst,
`ifdef CACHE_MEM_SLAVE_ERR_EN
   output logic err,
`endif
   ysyx_22040088_cache_mem_slave_if.slave bus
);
   localparam int unsigned IDX_W  = $clog2(MEM_WORDS);
   localparam int unsigned BEAT_W = $clog2(BEATS) + 32'd1;
   localparam int unsigned CNT_W  = (LAT > 32'd1) ? $clog2(LAT) : 32'd1;
   localparam logic [63:0] MEM_BYTES = 64'(MEM_WORDS) * 64'd8;
   localparam logic [IDX_W-1:0] LINE_MASK = ~IDX_W'(BEATS - 32'd1);
`ifdef CACHE_MEM_SLAVE_ERR_EN
   localparam logic [63:0] OOR_DATA = 64'hDEAD_BEEF_DEAD_BEEF;
`else
   localparam logic [63:0] OOR_DATA = 64'h0000_0000_0000_0000;
`endif

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      RD_RET  = 2'd2
   } state_t;

   function automatic logic [63:0] halfword_mask(input logic [3:0] wstrb);
      return {{16{wstrb[3]}}, {16{wstrb[2]}}, {16{wstrb[1]}}, {16{wstrb[0]}}};
   endfunction

   // Offset is taken in 64 bits, so addresses below BASE_ADDR wrap to huge offsets.
   function automatic logic addr_in_range(input logic [63:0] addr);
      return (addr >= BASE_ADDR) && ((addr - BASE_ADDR) < MEM_BYTES);
   endfunction

   logic [63:0]       mem_r [MEM_WORDS];
   state_t            state_r;
   logic [CNT_W-1:0]  cnt_r;
   logic [BEAT_W-1:0] beat_r;
   logic [IDX_W-1:0]  base_r;
   logic              oor_r;
   logic              ret_valid_r;
   logic              ret_last_r;
   logic [63:0]       ret_data_r;
`ifdef CACHE_MEM_SLAVE_ERR_EN
   logic              err_r;
`endif

   logic              idle_s;
   logic              rd_fire_s;
   logic              wr_fire_s;
   logic              rd_in_range_s;
   logic              wr_in_range_s;
   logic [63:0]       rd_off_s;
   logic [63:0]       wr_off_s;
   logic [IDX_W-1:0]  rd_idx_s;
   logic [IDX_W-1:0]  wr_idx_s;
   logic [IDX_W-1:0]  beat_idx_s;
   logic [63:0]       wr_mask_s;
   logic [63:0]       beat_data_s;
   logic              unused_s;

   assign idle_s        = (state_r == IDLE);
   assign rd_off_s      = bus.rd_addr - BASE_ADDR;
   assign wr_off_s      = bus.wr_addr - BASE_ADDR;
   assign rd_idx_s      = rd_off_s[IDX_W+2:3];
   assign wr_idx_s      = wr_off_s[IDX_W+2:3];
   assign rd_in_range_s = addr_in_range(bus.rd_addr);
   assign wr_in_range_s = addr_in_range(bus.wr_addr);
   assign wr_mask_s     = halfword_mask(bus.wr_wstrb);
   assign wr_fire_s     = idle_s & bus.wr_req & rst;
   assign rd_fire_s     = idle_s & bus.rd_req & ~bus.wr_req & rst;
   assign beat_idx_s    = base_r + IDX_W'(beat_r);
   assign beat_data_s   = oor_r ? OOR_DATA : mem_r[beat_idx_s];
   assign unused_s      = ^{bus.rd_wstrb, rd_off_s, wr_off_s};

   assign bus.rd_rdy    = idle_s & ~bus.wr_req;
   assign bus.wr_rdy    = idle_s;
   assign bus.ret_valid = ret_valid_r;
   assign bus.ret_last  = ret_last_r;
   assign bus.ret_data  = ret_data_r;
`ifdef CACHE_MEM_SLAVE_ERR_EN
   assign err           = err_r;
`endif

   // Backing store: masked halfword update on accepted in-range stores; never reset.
   always_ff @(posedge clk) begin
      if (wr_fire_s && wr_in_range_s) begin
         mem_r[wr_idx_s] <= (mem_r[wr_idx_s] & ~wr_mask_s) | (bus.wr_data & wr_mask_s);
      end
   end

   // Read FSM: latency countdown, then one registered beat per cycle until the line is done.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= IDLE;
         cnt_r       <= {CNT_W{1'b0}};
         beat_r      <= {BEAT_W{1'b0}};
         base_r      <= {IDX_W{1'b0}};
         oor_r       <= 1'b0;
         ret_valid_r <= 1'b0;
         ret_last_r  <= 1'b0;
         ret_data_r  <= 64'h0;
`ifdef CACHE_MEM_SLAVE_ERR_EN
         err_r       <= 1'b0;
`endif
      end else begin
         case (state_r)
            IDLE: begin
               if (rd_fire_s) begin
                  state_r <= RD_WAIT;
                  cnt_r   <= CNT_W'(LAT - 32'd1);
                  beat_r  <= {BEAT_W{1'b0}};
                  base_r  <= rd_idx_s & LINE_MASK;
                  oor_r   <= ~rd_in_range_s;
               end
`ifdef CACHE_MEM_SLAVE_ERR_EN
               if ((rd_fire_s && !rd_in_range_s) || (wr_fire_s && !wr_in_range_s)) begin
                  err_r <= 1'b1;
               end
`endif
            end
            RD_WAIT: begin
               if (cnt_r == {CNT_W{1'b0}}) begin
                  state_r     <= RD_RET;
                  ret_valid_r <= 1'b1;
                  ret_data_r  <= beat_data_s;
                  ret_last_r  <= (beat_r == BEAT_W'(BEATS - 32'd1));
                  beat_r      <= beat_r + BEAT_W'(32'd1);
               end else begin
                  cnt_r <= cnt_r - CNT_W'(32'd1);
               end
            end
            RD_RET: begin
               // Stay out of IDLE while the last beat is visible so rd_rdy stays low with it.
               if (ret_last_r) begin
                  state_r     <= IDLE;
                  ret_valid_r <= 1'b0;
                  ret_last_r  <= 1'b0;
                  ret_data_r  <= 64'h0;
               end else begin
                  ret_valid_r <= 1'b1;
                  ret_data_r  <= beat_data_s;
                  ret_last_r  <= (beat_r == BEAT_W'(BEATS - 32'd1));
                  beat_r      <= beat_r + BEAT_W'(32'd1);
               end
            end
            default: begin
               state_r     <= IDLE;
               ret_valid_r <= 1'b0;
               ret_last_r  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_ysyx_22040088_cache_mem_slave.sv
// Directed bench: single-beat instance (LAT=2) and 4-beat instance (LAT=3) side by side.
module tb_ysyx_22040088_cache_mem_slave;
   localparam int LAT_A = 2;
   localparam int LAT_B = 3;
`ifdef CACHE_MEM_SLAVE_ERR_EN
   localparam logic [63:0] OOR_EXP = 64'hDEAD_BEEF_DEAD_BEEF;
`else
   localparam logic [63:0] OOR_EXP = 64'h0;
`endif

   logic clk = 1'b0;
   logic rst;
   int   total;
   int   bad;

   ysyx_22040088_cache_mem_slave_if bus_a ();
   ysyx_22040088_cache_mem_slave_if bus_b ();
`ifdef CACHE_MEM_SLAVE_ERR_EN
   logic err_a;
   logic err_b;
`endif

   ysyx_22040088_cache_mem_slave #(.BEATS(1), .LAT(LAT_A)) u_dut_a (
      .clk (clk),
      .rst (rst),
`ifdef CACHE_MEM_SLAVE_ERR_EN
      .err (err_a),
`endif
      .bus (bus_a)
   );

   ysyx_22040088_cache_mem_slave #(.BEATS(4), .LAT(LAT_B)) u_dut_b (
      .clk (clk),
      .rst (rst),
`ifdef CACHE_MEM_SLAVE_ERR_EN
      .err (err_b),
`endif
      .bus (bus_b)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic write_a(input logic [63:0] addr, input logic [63:0] data, input logic [3:0] strb);
      @(posedge clk); #1;
      bus_a.wr_req   = 1'b1;
      bus_a.wr_addr  = addr;
      bus_a.wr_data  = data;
      bus_a.wr_wstrb = strb;
      @(negedge clk);
      check_eq("wr_rdy_a", 64'(bus_a.wr_rdy), 64'd1);
      @(posedge clk); #1;
      bus_a.wr_req = 1'b0;
   endtask

   task automatic write_b(input logic [63:0] addr, input logic [63:0] data);
      @(posedge clk); #1;
      bus_b.wr_req   = 1'b1;
      bus_b.wr_addr  = addr;
      bus_b.wr_data  = data;
      bus_b.wr_wstrb = 4'hF;
      @(posedge clk); #1;
      bus_b.wr_req = 1'b0;
   endtask

   // Called just after the acceptance edge T: beat must be visible after edge T+LAT_A.
   task automatic expect_ret_a(input string tag, input logic [63:0] exp);
      for (int c = 0; c < LAT_A; c++) begin
         @(negedge clk);
         check_eq({tag, "_early"}, 64'(bus_a.ret_valid), 64'd0);
      end
      @(negedge clk);
      check_eq({tag, "_valid"}, 64'(bus_a.ret_valid), 64'd1);
      check_eq({tag, "_last"}, 64'(bus_a.ret_last), 64'd1);
      check_eq({tag, "_data"}, bus_a.ret_data, exp);
      check_eq({tag, "_rdrdy_busy"}, 64'(bus_a.rd_rdy), 64'd0);
      @(negedge clk);
      check_eq({tag, "_done"}, 64'(bus_a.ret_valid), 64'd0);
      check_eq({tag, "_rdrdy_idle"}, 64'(bus_a.rd_rdy), 64'd1);
   endtask

   task automatic read_a(input string tag, input logic [63:0] addr, input logic [63:0] exp);
      @(posedge clk); #1;
      bus_a.rd_req  = 1'b1;
      bus_a.rd_addr = addr;
      @(negedge clk);
      check_eq({tag, "_accept"}, 64'(bus_a.rd_rdy), 64'd1);
      @(posedge clk); #1;
      bus_a.rd_req = 1'b0;
      expect_ret_a(tag, exp);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: sim time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b0;
      bus_a.rd_req = 1'b0; bus_a.rd_wstrb = 4'h0; bus_a.rd_addr = 64'h0;
      bus_a.wr_req = 1'b0; bus_a.wr_wstrb = 4'h0; bus_a.wr_addr = 64'h0; bus_a.wr_data = 64'h0;
      bus_b.rd_req = 1'b0; bus_b.rd_wstrb = 4'h0; bus_b.rd_addr = 64'h0;
      bus_b.wr_req = 1'b0; bus_b.wr_wstrb = 4'h0; bus_b.wr_addr = 64'h0; bus_b.wr_data = 64'h0;

      repeat (2) @(negedge clk);
      check_eq("rst_valid", 64'(bus_a.ret_valid), 64'd0);
      check_eq("rst_last", 64'(bus_a.ret_last), 64'd0);
      check_eq("rst_data", bus_a.ret_data, 64'h0);
      check_eq("rst_rd_rdy", 64'(bus_a.rd_rdy), 64'd1);
      check_eq("rst_wr_rdy", 64'(bus_a.wr_rdy), 64'd1);
`ifdef CACHE_MEM_SLAVE_ERR_EN
      check_eq("rst_err", 64'(err_a), 64'd0);
`endif
      @(posedge clk); #1;
      rst = 1'b1;

      // Full-word write then refill
      write_a(64'h8000_0008, 64'h0011_2233_4455_6677, 4'hF);
      read_a("rd1", 64'h8000_0008, 64'h0011_2233_4455_6677);

      // Halfword-masked write
      write_a(64'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 4'hF);
      write_a(64'h8000_0010, 64'h0, 4'b0101);
      read_a("partial", 64'h8000_0010, 64'hFFFF_0000_FFFF_0000);

      // Simultaneous write and read: write wins, read follows next cycle
      @(posedge clk); #1;
      bus_a.wr_req   = 1'b1;
      bus_a.wr_addr  = 64'h8000_0018;
      bus_a.wr_data  = 64'hA5A5_5A5A_0F0F_F0F0;
      bus_a.wr_wstrb = 4'hF;
      bus_a.rd_req   = 1'b1;
      bus_a.rd_addr  = 64'h8000_0018;
      @(negedge clk);
      check_eq("simul_wr_rdy", 64'(bus_a.wr_rdy), 64'd1);
      check_eq("simul_rd_rdy", 64'(bus_a.rd_rdy), 64'd0);
      @(posedge clk); #1;
      bus_a.wr_req = 1'b0;
      @(negedge clk);
      check_eq("simul_rd_rdy_next", 64'(bus_a.rd_rdy), 64'd1);
      @(posedge clk); #1;
      bus_a.rd_req = 1'b0;
      expect_ret_a("simul", 64'hA5A5_5A5A_0F0F_F0F0);

      // Range boundaries: aliasing out-of-range writes must not land
      write_a(64'h8000_0000, 64'h1234_5678_9ABC_DEF0, 4'hF);
      write_a(64'h8000_1FF8, 64'h0BAD_CAFE_0000_0001, 4'hF);
`ifdef CACHE_MEM_SLAVE_ERR_EN
      check_eq("err_inrange", 64'(err_a), 64'd0);
`endif
      write_a(64'h8000_2000, 64'hFFFF_EEEE_DDDD_CCCC, 4'hF);
      write_a(64'h7FFF_FFF8, 64'h1111_2222_3333_4444, 4'hF);
      read_a("word0", 64'h8000_0000, 64'h1234_5678_9ABC_DEF0);
      read_a("lastword", 64'h8000_1FF8, 64'h0BAD_CAFE_0000_0001);
      read_a("oor_rd", 64'h7FFF_FFF8, OOR_EXP);
`ifdef CACHE_MEM_SLAVE_ERR_EN
      repeat (10) @(negedge clk);
      check_eq("err_sticky", 64'(err_a), 64'd1);
`endif

      // Four-beat line, LAT=3; both requests map to line base 0x80000020
      write_b(64'h8000_0020, 64'd1);
      write_b(64'h8000_0028, 64'd2);
      write_b(64'h8000_0030, 64'd3);
      write_b(64'h8000_0038, 64'd4);
      for (int r = 0; r < 2; r++) begin
         @(posedge clk); #1;
         bus_b.rd_req  = 1'b1;
         bus_b.rd_addr = (r == 0) ? 64'h8000_0030 : 64'h8000_0028;
         @(negedge clk);
         check_eq("b_accept", 64'(bus_b.rd_rdy), 64'd1);
         @(posedge clk); #1;
         bus_b.rd_req = 1'b0;
         for (int c = 0; c < LAT_B; c++) begin
            @(negedge clk);
            check_eq("b_early", 64'(bus_b.ret_valid), 64'd0);
         end
         for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_eq("b_valid", 64'(bus_b.ret_valid), 64'd1);
            check_eq("b_data", bus_b.ret_data, 64'(k + 1));
            check_eq("b_last", 64'(bus_b.ret_last), (k == 3) ? 64'd1 : 64'd0);
            check_eq("b_rd_rdy_busy", 64'(bus_b.rd_rdy), 64'd0);
         end
         @(negedge clk);
         check_eq("b_done", 64'(bus_b.ret_valid), 64'd0);
         check_eq("b_rd_rdy_idle", 64'(bus_b.rd_rdy), 64'd1);
      end

      // Reset during RD_WAIT aborts the read
      @(posedge clk); #1;
      bus_a.rd_req  = 1'b1;
      bus_a.rd_addr = 64'h8000_0008;
      @(posedge clk); #1;
      bus_a.rd_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check_eq("abort_in_rst", 64'(bus_a.ret_valid), 64'd0);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check_eq("abort_after_rst", 64'(bus_a.ret_valid), 64'd0);
      end
`ifdef CACHE_MEM_SLAVE_ERR_EN
      check_eq("err_cleared", 64'(err_a), 64'd0);
`endif
      read_a("post_rst", 64'h8000_0008, 64'h0011_2233_4455_6677);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/ysyx_22040088_cache_mem_slave.md
Name: ysyx_22040088_cache_mem_slave

Overview:
- Memory-side responder for the cache refill/write-back interface driven by ysyx_22040088 L1 caches: serves `rd_req` line refills and `wr_req` stores.
- Owns a word-addressed 64-bit backing store, used as main memory in the NPC simulation top.
- Returns refill data as `ret_valid` beats after a fixed, programmable latency; one outstanding transaction at a time.

Parameters:
- BASE_ADDR, 64'h80000000, byte address mapped to word 0.
- MEM_WORDS, 1024, number of 64-bit words (power of 2).
- BEATS, 1, 64-bit beats per refill line (1, 2, 4 or 8).
- LAT, 2, cycles from read acceptance edge to first ret_valid (>=1).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low (asserted at 0).
- rd_req  in  1  refill request.
- rd_wstrb  in  4  ignored; a refill always returns the full line.
- rd_addr  in  64  refill byte address.
- rd_rdy  out  1  refill request accepted this cycle when rd_req is also high.
- ret_valid  out  1  refill beat valid.
- ret_last  out  1  final beat of the line.
- ret_data  out  64  refill beat data.
- wr_req  in  1  store request (single 64-bit beat).
- wr_wstrb  in  4  halfword enables; bit i enables wr_data[16i+15:16i].
- wr_addr  in  64  store byte address.
- wr_data  in  64  store data.
- wr_rdy  out  1  store accepted this cycle when wr_req is also high.

Behaviour:
- FSM states: IDLE, RD_WAIT, RD_RET.
- Reset (rst=0, async): FSM goes to IDLE; ret_valid=0, ret_last=0, ret_data=0; latency counter and beat counter are 0.
  - Backing store is not reset.
  - rd_rdy = IDLE & ~wr_req. wr_rdy = IDLE. After reset, rd_rdy=1 and wr_rdy=1 when no request is pending.
- Write acceptance (IDLE, wr_req=1):
  - Accepted at the edge; masked halfwords are written at that same edge; FSM stays IDLE.
  - Write has priority: rd_rdy is held 0 while wr_req=1.
  - A read accepted on a later cycle returns the written data.
- Read acceptance (IDLE, rd_req & rd_rdy):
  - Latch word index = (rd_addr - BASE_ADDR) >> 3, with the low log2(BEATS) bits cleared (line-aligned).
  - Load counter = LAT-1 and enter RD_WAIT.
- RD_WAIT: counter decrements each cycle. When it reaches 0, go to RD_RET.
  - First ret_valid appears exactly LAT cycles after the acceptance edge.
- RD_RET:
  - One beat per cycle, with no back-pressure; beat k returns word base+k, k = 0..BEATS-1.
  - ret_last=1 only on beat BEATS-1.
  - After the last beat, return to IDLE; rd_rdy may be 1 in the cycle after ret_last.
- Outside IDLE: rd_rdy=0 and wr_rdy=0. Requests are held by the requester, never dropped silently.
- Index arithmetic: offset is computed in 64 bits and the word index wraps modulo MEM_WORDS.
- Out-of-range address (addr < BASE_ADDR or addr >= BASE_ADDR + MEM_WORDS*8):
  - Read beats return 64'h0 with normal timing.
  - Writes are accepted and dropped.
- ret_data/ret_valid are registered outputs; rd_rdy/wr_rdy are combinational from state and wr_req.
- Reset mid-read (RD_WAIT or RD_RET): transaction aborted. ret_valid drops asynchronously and no further beats are issued.
- Simultaneous rd_req and wr_req in IDLE: write accepted first; read accepted the following cycle if still asserted.

Optional Feature:
- Macro CACHE_MEM_SLAVE_ERR_EN.
- Defined:
  - Adds output `err` (1 bit), reset 0.
  - Sticky-set on acceptance of any out-of-range read or write; cleared only by reset.
  - Out-of-range reads also return 64'hDEADBEEF_DEADBEEF instead of 0.
- Undefined: no `err` port; out-of-range behaviour as in Behaviour.

Test Plan:
- Reset release, LAT=2, BEATS=1:
  - Stimulus: write 64'h0011223344556677 to 0x80000008 with wstrb 4'hF; then rd_req to 0x80000008 accepted at edge T.
  - Required: ret_valid=1, ret_last=1, ret_data=64'h0011223344556677 in the cycle after edge T+2; rd_rdy=0 through that cycle.
- Partial write:
  - Stimulus: word 0x80000010 = 64'hFFFFFFFFFFFFFFFF; write wr_data=0 with wstrb 4'b0101; then read 0x80000010.
  - Required: ret_data=64'hFFFF0000FFFF0000.
- BEATS=4, LAT=3:
  - Stimulus: words 0x80000020..0x80000038 = 1,2,3,4; rd_addr=0x80000030.
  - Required: 4 consecutive beats 1,2,3,4; ret_last only on the 4th beat; first beat 3 cycles after acceptance.
- Simultaneous rd_req/wr_req in IDLE:
  - Required: wr_rdy=1, rd_rdy=0 in that cycle; read accepted next cycle and returns the new data.
- Out-of-range read at 0x7FFFFFF8:
  - Required: ret_data=0 with normal timing.
  - With CACHE_MEM_SLAVE_ERR_EN: ret_data=64'hDEADBEEFDEADBEEF and err=1, still 1 after 10 idle cycles.
- Reset mid-read:
  - Stimulus: assert rst=0 during RD_WAIT.
  - Required: ret_valid never asserts for that request; after release, a new read completes normally.
